// File: rtl/conv_input_word_writer.sv
// conv_input_word_writer: receive side of the conv input-load path.
// Matches each DDR read-return word with its load-info FIFO entry and writes
// it into the addressed input row buffer. It also counts the words written
// per layer load, pulses done at completion and keeps sticky protocol-error
// flags.
module conv_input_word_writer #(
  parameter int WORD_W  = 512,
  parameter int INFO_W  = 32,
  parameter int BUF_NUM = 4,
  parameter int ADR_W   = 16,
  parameter int DDR_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [15:0]         expected_words,
  input  logic                ddr_en_rd,
  input  logic [WORD_W-1:0]   ddr_rd_data,
  input  logic                info_fifo_empty,
  input  logic [INFO_W-1:0]   info_fifo_dout,
  output logic                info_fifo_rd_en,
  output logic [BUF_NUM-1:0]  buf_en_wr,
  output logic [ADR_W-1:0]    buf_adr_wr,
  output logic [WORD_W-1:0]   buf_word_wr,
  output logic [15:0]         words_written,
  output logic                busy,
  output logic                done,
  output logic                underflow_err,
  output logic                idx_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;

  logic [DDR_LAT-1:0]   rd_dly_p0;
  logic                 rd_vld_p0;
  logic                 vld_p1;
  logic [WORD_W-1:0]    word_p1;

  logic [15:0]          target_q;
  logic [15:0]          ww_next;
  logic [15:0]          info_idx;
  logic                 load;
  logic                 drop;
  logic                 count;

  // One-hot write enable for a buffer index; out-of-range indices give no enable.
  function automatic logic [BUF_NUM-1:0] idx_onehot(input logic [15:0] idx);
    logic [BUF_NUM-1:0] r;
    r = '0;
    for (int i = 0; i < BUF_NUM; i++) begin
      r[i] = (idx == 16'(i));
    end
    return r;
  endfunction

  function automatic logic idx_bad(input logic [15:0] idx);
    return (idx >= 16'(BUF_NUM));
  endfunction

  assign rd_vld_p0 = rd_dly_p0[DDR_LAT-1];
  assign info_idx  = info_fifo_dout[15:0];
  assign ww_next   = words_written + 16'd1;
  // Only words reaching stage 2 while the load is running are counted;
  // stragglers after the target still get written.
  assign count     = (state_q == S_RUN) && vld_p1;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, FIFO pop and status outputs.
  always_comb begin
    state_d         = state_q;
    busy            = 1'b0;
    done            = 1'b0;
    load            = 1'b0;
    drop            = 1'b0;
    info_fifo_rd_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy            = 1'b1;
        info_fifo_rd_en = rd_vld_p0 && !info_fifo_empty;
        drop            = rd_vld_p0 && info_fifo_empty;
        if (target_q == 16'd0) begin
          state_d = S_DONE;
        end else if (vld_p1 && (ww_next == target_q)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- stage 0: read-request delay line aligned with DDR return data ----
  // Shift ddr_en_rd through DDR_LAT flops so rd_vld_p0 lines up with ddr_rd_data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_dly_p0 <= '0;
    end else begin
      rd_dly_p0[0] <= ddr_en_rd;
      for (int i = 1; i < DDR_LAT; i++) begin
        rd_dly_p0[i] <= rd_dly_p0[i-1];
      end
    end
  end

  // ---- stage 1: capture the returned word while the FIFO entry is popped ----
  // Hold the DDR word for one cycle until its FIFO entry appears on dout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      word_p1 <= '0;
    end else begin
      vld_p1 <= info_fifo_rd_en;
      if (info_fifo_rd_en) begin
        word_p1 <= ddr_rd_data;
      end
    end
  end

  // ---- stage 2: FIFO entry valid, register the row-buffer write ----
  // Strobe is a single cycle per word; address and data hold between writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_en_wr   <= '0;
      buf_adr_wr  <= '0;
      buf_word_wr <= '0;
    end else begin
      buf_en_wr <= vld_p1 ? idx_onehot(info_idx) : '0;
      if (vld_p1) begin
        buf_adr_wr  <= ADR_W'(info_fifo_dout[31:16]);
        buf_word_wr <= word_p1;
      end
    end
  end

  // Per-load target, word counter and sticky error flags; start clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target_q      <= '0;
      words_written <= '0;
      underflow_err <= 1'b0;
      idx_err       <= 1'b0;
    end else if (load) begin
      target_q      <= expected_words;
      words_written <= '0;
      underflow_err <= 1'b0;
      idx_err       <= 1'b0;
    end else begin
      if (count) begin
        words_written <= ww_next;
      end
      if (drop) begin
        underflow_err <= 1'b1;
      end
      if (vld_p1 && idx_bad(info_idx)) begin
        idx_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_input_word_writer.sv
// Directed bench for conv_input_word_writer with a small standard-FIFO model
// and a DDR return-latency model around the DUT.
module tb_conv_input_word_writer;

  localparam int WORD_W  = 512;
  localparam int INFO_W  = 32;
  localparam int BUF_NUM = 4;
  localparam int ADR_W   = 16;
  localparam int DDR_LAT = 1;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic [15:0]         expected_words = '0;
  logic                ddr_en_rd = 1'b0;
  logic [WORD_W-1:0]   req_word = '0;
  logic [WORD_W-1:0]   ddr_rd_data;
  logic                info_fifo_empty;
  logic [INFO_W-1:0]   info_fifo_dout = '0;
  logic                info_fifo_rd_en;
  logic [BUF_NUM-1:0]  buf_en_wr;
  logic [ADR_W-1:0]    buf_adr_wr;
  logic [WORD_W-1:0]   buf_word_wr;
  logic [15:0]         words_written;
  logic                busy;
  logic                done;
  logic                underflow_err;
  logic                idx_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conv_input_word_writer #(
    .WORD_W(WORD_W), .INFO_W(INFO_W), .BUF_NUM(BUF_NUM), .ADR_W(ADR_W), .DDR_LAT(DDR_LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .expected_words(expected_words),
    .ddr_en_rd(ddr_en_rd), .ddr_rd_data(ddr_rd_data),
    .info_fifo_empty(info_fifo_empty), .info_fifo_dout(info_fifo_dout),
    .info_fifo_rd_en(info_fifo_rd_en), .buf_en_wr(buf_en_wr), .buf_adr_wr(buf_adr_wr),
    .buf_word_wr(buf_word_wr), .words_written(words_written), .busy(busy), .done(done),
    .underflow_err(underflow_err), .idx_err(idx_err)
  );

  // DDR model: data requested in a cycle returns DDR_LAT cycles later.
  logic [WORD_W-1:0] ddr_dly [DDR_LAT];
  always @(posedge clk) begin
    ddr_dly[0] <= req_word;
    for (int i = 1; i < DDR_LAT; i++) ddr_dly[i] <= ddr_dly[i-1];
  end
  assign ddr_rd_data = ddr_dly[DDR_LAT-1];

  // Standard (non-FWFT) FIFO model: dout updates on the edge after rd_en.
  logic [31:0] fifo_mem [64];
  logic [5:0]  wr_ptr = '0;
  logic [5:0]  rd_ptr = '0;
  assign info_fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (info_fifo_rd_en && !info_fifo_empty) begin
      info_fifo_dout <= fifo_mem[rd_ptr];
      rd_ptr <= rd_ptr + 6'd1;
    end
  end

  task automatic push(input logic [15:0] adr, input logic [15:0] idx);
    fifo_mem[wr_ptr] = {adr, idx};
    wr_ptr = wr_ptr + 6'd1;
  endtask

  function automatic logic [WORD_W-1:0] mkword(input logic [7:0] t);
    return {16{24'hC0FFEE, t}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_word(input string nm, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        start;
    logic [15:0] ew;
    logic        en;
    logic [7:0]  tag;
    logic        x_rd;
    logic [3:0]  x_en;
    logic        x_busy;
    logic        x_done;
    logic [15:0] x_ww;
    logic        chk_wr;
    logic [15:0] x_adr;
    logic [7:0]  x_tag;
  } vec_t;

  function automatic vec_t mkrow(int st, int ew, int en, int tag, int xrd, int xen,
                                 int xbusy, int xdone, int xww, int cw, int xadr, int xtag);
    vec_t v;
    v.start = 1'(st);   v.ew = 16'(ew);      v.en = 1'(en);       v.tag = 8'(tag);
    v.x_rd = 1'(xrd);   v.x_en = 4'(xen);    v.x_busy = 1'(xbusy); v.x_done = 1'(xdone);
    v.x_ww = 16'(xww);  v.chk_wr = 1'(cw);   v.x_adr = 16'(xadr); v.x_tag = 8'(xtag);
    return v;
  endfunction

  vec_t tbl [8];

  initial begin
    // Back-to-back load of three words: strobes start three cycles after the first request.
    tbl[0] = mkrow(1, 3, 0, 0,  0, 4'b0000, 0, 0, 0, 0, 0,     0);
    tbl[1] = mkrow(0, 0, 1, 1,  0, 4'b0000, 1, 0, 0, 0, 0,     0);
    tbl[2] = mkrow(0, 0, 1, 2,  1, 4'b0000, 1, 0, 0, 0, 0,     0);
    tbl[3] = mkrow(0, 0, 1, 3,  1, 4'b0000, 1, 0, 0, 0, 0,     0);
    tbl[4] = mkrow(0, 0, 0, 0,  1, 4'b0001, 1, 0, 1, 1, 16'h10, 1);
    tbl[5] = mkrow(0, 0, 0, 0,  0, 4'b0010, 1, 0, 2, 1, 16'h11, 2);
    tbl[6] = mkrow(0, 0, 0, 0,  0, 4'b1000, 0, 1, 3, 1, 16'h12, 3);
    tbl[7] = mkrow(0, 0, 0, 0,  0, 4'b0000, 0, 0, 3, 1, 16'h12, 3);

    // Reset state
    #12;
    chk("rst_state", {27'd0, info_fifo_rd_en, buf_en_wr},          32'd0);
    chk("rst_flags", {12'd0, words_written, busy, done, underflow_err, idx_err}, 32'd0);
    tick();
    #2 reset = 1'b1;

    // Table-driven main load
    push(16'h0010, 16'd0);
    push(16'h0011, 16'd1);
    push(16'h0012, 16'd3);
    for (int i = 0; i < 8; i++) begin
      tick();
      start = tbl[i].start;
      expected_words = tbl[i].ew;
      ddr_en_rd = tbl[i].en;
      req_word = mkword(tbl[i].tag);
      #1;
      chk($sformatf("vec%0d_ctl", i),
          {9'd0, info_fifo_rd_en, buf_en_wr, busy, done, words_written},
          {9'd0, tbl[i].x_rd, tbl[i].x_en, tbl[i].x_busy, tbl[i].x_done, tbl[i].x_ww});
      if (tbl[i].chk_wr) begin
        chk($sformatf("vec%0d_adr", i), {16'd0, buf_adr_wr}, {16'd0, tbl[i].x_adr});
        chk_word($sformatf("vec%0d_word", i), buf_word_wr, mkword(tbl[i].x_tag));
      end
    end
    chk("main_no_errs", {30'd0, underflow_err, idx_err}, 32'd0);

    // Underflow: a return with the FIFO empty is dropped
    tick(); start = 1'b1; expected_words = 16'd1;
    tick(); start = 1'b0; ddr_en_rd = 1'b1; req_word = mkword(8'h33); #1;
    chk("ufl_busy", {31'd0, busy}, 32'd1);
    tick(); ddr_en_rd = 1'b0; #1;
    chk("ufl_no_pop", {31'd0, info_fifo_rd_en}, 32'd0);
    tick(); #1;
    chk("ufl_flag", {31'd0, underflow_err}, 32'd1);
    chk("ufl_ww", {16'd0, words_written}, 32'd0);
    tick(); #1;
    chk("ufl_no_write", {28'd0, buf_en_wr}, 32'd0);
    // complete that load with a real word into buffer 2
    push(16'h0030, 16'd2);
    ddr_en_rd = 1'b1; req_word = mkword(8'h40);
    tick(); ddr_en_rd = 1'b0; #1;
    chk("ufl_pop", {31'd0, info_fifo_rd_en}, 32'd1);
    tick();
    tick(); #1;
    chk("ufl_wr_en", {28'd0, buf_en_wr}, 32'b0100);
    chk_word("ufl_wr_word", buf_word_wr, mkword(8'h40));
    chk("ufl_done", {30'd0, done, underflow_err}, 32'b11);

    // Zero-word load: done two cycles after start; start clears underflow
    tick(); #1;
    chk("idle_after_done", {30'd0, busy, done}, 32'd0);
    start = 1'b1; expected_words = 16'd0;
    tick(); start = 1'b0; #1;
    chk("zero_run", {14'd0, busy, underflow_err, words_written}, {14'd0, 1'b1, 1'b0, 16'd0});
    tick(); #1;
    chk("zero_done", {27'd0, done, buf_en_wr}, {27'd0, 1'b1, 4'b0000});
    tick(); #1;
    chk("zero_idle", {30'd0, busy, done}, 32'd0);

    // Out-of-range buffer index: no write, flagged, still counted
    start = 1'b1; expected_words = 16'd1;
    push(16'h0020, 16'd5);
    tick(); start = 1'b0; ddr_en_rd = 1'b1; req_word = mkword(8'h50);
    tick(); ddr_en_rd = 1'b0; #1;
    chk("idx_pop", {31'd0, info_fifo_rd_en}, 32'd1);
    tick();
    tick(); #1;
    chk("idx_no_write", {28'd0, buf_en_wr}, 32'd0);
    chk("idx_flag", {31'd0, idx_err}, 32'd1);
    chk("idx_counted", {15'd0, done, words_written}, {15'd0, 1'b1, 16'd1});

    // Returns in IDLE are ignored
    tick();
    push(16'h0040, 16'd0);
    ddr_en_rd = 1'b1; req_word = mkword(8'h5F);
    tick(); ddr_en_rd = 1'b0; #1;
    chk("idle_no_pop", {31'd0, info_fifo_rd_en}, 32'd0);
    tick(); #1;
    chk("idle_no_wr1", {28'd0, buf_en_wr}, 32'd0);
    tick(); #1;
    chk("idle_no_wr2", {28'd0, buf_en_wr}, 32'd0);
    chk("idle_fifo_kept", {26'd0, wr_ptr - rd_ptr}, 32'd1);

    // Second start during RUN must not relatch expected_words
    start = 1'b1; expected_words = 16'd2;
    tick(); start = 1'b1; expected_words = 16'd1;
    ddr_en_rd = 1'b1; req_word = mkword(8'h61);
    push(16'h0041, 16'd1);
    tick(); start = 1'b0; ddr_en_rd = 1'b1; req_word = mkword(8'h62); #1;
    chk("rs_pop1", {31'd0, info_fifo_rd_en}, 32'd1);
    tick(); ddr_en_rd = 1'b0; #1;
    chk("rs_pop2", {31'd0, info_fifo_rd_en}, 32'd1);
    tick(); #1;
    chk("rs_wr1", {11'd0, buf_en_wr, busy, done, words_written}, {11'd0, 4'b0001, 1'b1, 1'b0, 16'd1});
    chk("rs_adr1", {16'd0, buf_adr_wr}, 32'h0040);
    chk_word("rs_word1", buf_word_wr, mkword(8'h61));
    tick(); #1;
    chk("rs_wr2", {11'd0, buf_en_wr, busy, done, words_written}, {11'd0, 4'b0010, 1'b0, 1'b1, 16'd2});
    chk_word("rs_word2", buf_word_wr, mkword(8'h62));

    // Asynchronous reset with writes in flight
    tick(); start = 1'b1; expected_words = 16'd5;
    push(16'h0050, 16'd0);
    push(16'h0051, 16'd1);
    push(16'h0052, 16'd2);
    tick(); start = 1'b0; ddr_en_rd = 1'b1; req_word = mkword(8'h70);
    tick(); req_word = mkword(8'h71);
    tick(); req_word = mkword(8'h72);
    tick(); ddr_en_rd = 1'b0; #1;
    chk("pre_rst_wr", {28'd0, buf_en_wr}, 32'b0001);
    #2 reset = 1'b0;
    #1;
    chk("async_rst", {11'd0, buf_en_wr, busy, done, words_written}, 32'd0);
    tick();
    #2 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      chk($sformatf("post_rst%0d", i), {26'd0, info_fifo_rd_en, buf_en_wr, busy}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_input_word_writer.md
Name: conv_input_word_writer

Overview:
- Receive side of the conv input-load path: consumes DDR read-return words (DDR_LAT cycles after each read request) and pops the matching load-info FIFO entry.
- Writes each 512-bit word into the addressed input row buffer; the entry's low half selects the buffer, its high half gives the buffer address.
- Counts written words per layer load, pulses done, and flags protocol errors.
- Sits between DDR/MIG, the load-info FIFO and the input row buffers.

Parameters:
- WORD_W, 512, DDR/row-buffer word width
- INFO_W, 32, load-info FIFO entry width; [15:0] = buffer index, [31:16] = buffer address
- BUF_NUM, 4, number of input row buffers
- ADR_W, 16, row-buffer address width
- DDR_LAT, 1, cycles from ddr_en_rd to valid ddr_rd_data (range 1..4)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a layer load
- expected_words  in  16  words to write for this load, sampled on start
- ddr_en_rd  in  1  read request issued to DDR (same signal the load controller drives)
- ddr_rd_data  in  WORD_W  DDR read data
- info_fifo_empty  in  1  load-info FIFO empty
- info_fifo_dout  in  INFO_W  FIFO data, valid 1 cycle after rd_en (standard, non-FWFT)
- info_fifo_rd_en  out  1  FIFO pop
- buf_en_wr  out  BUF_NUM  one-hot row-buffer write enable
- buf_adr_wr  out  ADR_W  row-buffer write address
- buf_word_wr  out  WORD_W  row-buffer write data
- words_written  out  16  words written in the current load
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse on load completion
- underflow_err  out  1  sticky: data returned while FIFO empty
- idx_err  out  1  sticky: buffer index >= BUF_NUM

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM=IDLE, delay line and pipeline registers cleared. Reset mid-load discards all in-flight words; no write issued after reset deasserts until new data arrives in RUN.
- Return tracking: ddr_en_rd passes through a DDR_LAT-deep shift register; its output is rd_valid, aligned with ddr_rd_data.
- Stage 1 (cycle T, rd_valid=1, FSM=RUN):
  - FIFO not empty: info_fifo_rd_en=1 (combinational), ddr_rd_data captured into word_q, s1_valid set.
  - FIFO empty: no pop, word dropped, underflow_err set.
- Stage 2 (cycle T+1): info_fifo_dout valid. Registered at the end of T+1: buf_en_wr = one-hot(dout[15:0]), buf_adr_wr = dout[31:16], buf_word_wr = word_q.
  - If dout[15:0] >= BUF_NUM: buf_en_wr=0, idx_err set, word still counted.
- Write strobe is visible in cycle T+2: latency rd_valid -> buf_en_wr = 2 cycles. Fully pipelined at 1 word/cycle; back-to-back returns give back-to-back writes.
- buf_en_wr is 0 in every cycle without a stage-2 word. buf_adr_wr and buf_word_wr hold their last value.
- FSM:
  - IDLE: start=1 latches expected_words, clears words_written, underflow_err and idx_err, goes to RUN.
  - RUN: busy=1. words_written increments on each stage-2 word (16-bit, wraps). When the increment brings words_written to the latched target, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - expected_words=0: RUN lasts one cycle, then DONE.
- start while in RUN or DONE is ignored.
- rd_valid in IDLE or DONE: no pop, no write, underflow_err unchanged.
- Words still in the pipeline when the target is reached complete their writes but are not counted.
- Error flags and words_written hold after DONE until the next start.

Test Plan:
- Reset (reset=0) mid-pipeline -> buf_en_wr=0, busy=0, words_written=0 immediately (asynchronous); no write strobe appears after reset releases.
- start with expected_words=3; FIFO preloaded {adr=0x0010,idx=0}, {0x0011,1}, {0x0012,3}; three back-to-back ddr_en_rd -> buf_en_wr = 0001, 0010, 1000 on consecutive cycles starting 1+DDR_LAT+1 cycles after the first request; adr 0x10/0x11/0x12; data matches DDR; done pulses once; words_written=3.
- One return with the FIFO empty -> info_fifo_rd_en=0, no write, underflow_err=1; the next start clears it.
- FIFO entry idx=5 -> buf_en_wr=0, idx_err=1, words_written still increments.
- expected_words=0 -> done 2 cycles after start, no writes.
- Returns arriving in IDLE -> no pop, no write; a second start during RUN does not relatch expected_words.
